// File: rtl/tdp18k_fifo_rd_stream_if.sv
// Bundles for the read-side FIFO stream: the TDP18K FIFO read port and the
// downstream valid/ready stream. Signal names follow the primitive/stream pins.

// FIFO read port. The master is the read-stream block and the slave is the FIFO primitive.
interface tdp18k_fifo_rd_if #(
  parameter int DW = 18
);
  logic          FIFO_EMPTY_i;
  logic          FIFO_EPO_i;
  logic          FIFO_UNDERRUN_i;
  logic [DW-1:0] FIFO_RDATA_i;
  logic          FIFO_REN_o;
  logic          FIFO_FLUSH_no;

  modport master (
    input  FIFO_EMPTY_i, FIFO_EPO_i, FIFO_UNDERRUN_i, FIFO_RDATA_i,
    output FIFO_REN_o, FIFO_FLUSH_no
  );
  modport slave (
    output FIFO_EMPTY_i, FIFO_EPO_i, FIFO_UNDERRUN_i, FIFO_RDATA_i,
    input  FIFO_REN_o, FIFO_FLUSH_no
  );
endinterface

// Stream handshake: a beat transfers on a rising edge where M_VALID_o & M_READY_i.
// Once M_VALID_o is high, M_VALID_o and M_DATA_o stay stable until that beat transfers.
// M_READY_i may change freely and does not depend on M_VALID_o.
interface tdp18k_stream_if #(
  parameter int DW = 18
);
  logic          M_VALID_o;
  logic          M_READY_i;
  logic [DW-1:0] M_DATA_o;

  modport master (output M_VALID_o, M_DATA_o, input M_READY_i);
  modport slave  (input M_VALID_o, M_DATA_o, output M_READY_i);
endinterface

// File: rtl/tdp18k_fifo_rd_stream.sv
// Read-side master for a TDP18K FIFO: issues credit-limited REN, lands read data
// into a skid buffer, streams it out, and sequences drain/flush with sticky errors.
module tdp18k_fifo_rd_stream #(
  parameter int DATA_WIDTH   = 18,
  parameter int RD_LAT       = 1,
  parameter int SKID_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                    CLK_i,
  input  logic                    RST_i,
  tdp18k_fifo_rd_if.master        fifo,
  tdp18k_stream_if.master         m_stream,
  input  logic                    FLUSH_REQ_i,
  output logic                    BUSY_o,
  output logic                    ERR_o,
  output logic [15:0]             WORD_CNT_o,
  output logic [1:0]              DBG_STATE_o
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int CW = $clog2(SKID_DEPTH + RD_LAT + 1) + 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  logic [RD_LAT-1:0]     r_tag;
  logic                  r_last_taken;
  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [OW-1:0]         r_occ;
  logic [FW-1:0]         r_flush_cnt;
  logic                  r_flush_n;
  logic                  r_err;
  logic [15:0]           r_word_cnt;

  logic [CW-1:0] w_inflight;
  logic [CW-1:0] w_credit;
  logic          w_ren;
  logic          w_land;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_ovf;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;

  // Each set tag bit is one read whose data has not yet been written into the skid buffer.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_tag[i]);
    end
  end

  assign w_credit = w_inflight + CW'(r_occ);
  // Reads are never speculative: last_taken covers the cycle where EMPTY lags the final read.
  assign w_ren    = ~RST_i & (r_state == S_RUN) & ~fifo.FIFO_EMPTY_i & ~r_last_taken
                    & (w_credit < CW'(SKID_DEPTH));
  assign w_land   = r_tag[RD_LAT-1];
  assign w_pop    = (r_occ != '0) & m_stream.M_READY_i;
  assign w_full   = (r_occ == OW'(SKID_DEPTH));
  assign w_push   = w_land & (r_state == S_RUN) & (~w_full | w_pop);
  assign w_ovf    = w_land & (r_state == S_RUN) & w_full & ~w_pop;

  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(SKID_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(SKID_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_state      <= S_RUN;
      r_tag        <= '0;
      r_last_taken <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_flush_cnt  <= '0;
      r_flush_n    <= 1'b1;
      r_err        <= 1'b0;
      r_word_cnt   <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_tag        <= (r_tag << 1) | RD_LAT'(w_ren);
      r_last_taken <= w_ren & fifo.FIFO_EPO_i;
      r_err        <= r_err | fifo.FIFO_UNDERRUN_i | w_ovf;
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + 16'd1;
        r_rd_ptr   <= w_rd_ptr_nxt;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= fifo.FIFO_RDATA_i;
        r_wr_ptr        <= w_wr_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: ;
      endcase

      case (r_state)
        S_RUN: begin
          if (FLUSH_REQ_i) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Skid contents are abandoned together with the FIFO contents.
          if (w_inflight == '0) begin
            r_state     <= S_FLUSH;
            r_flush_n   <= 1'b0;
            r_flush_cnt <= FW'(FLUSH_CYCLES - 1);
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state   <= S_RUN;
            r_flush_n <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign fifo.FIFO_REN_o    = w_ren;
  assign fifo.FIFO_FLUSH_no = r_flush_n;
  assign m_stream.M_VALID_o = (r_occ != '0);
  assign m_stream.M_DATA_o  = r_mem[r_rd_ptr];
  assign BUSY_o             = (r_state != S_RUN);
  assign ERR_o              = r_err;
  assign WORD_CNT_o         = r_word_cnt;
  assign DBG_STATE_o        = r_state;

endmodule

// File: tb/tb_tdp18k_fifo_rd_stream.sv
// Bench for tdp18k_fifo_rd_stream: two instances (RD_LAT=1 and RD_LAT=2), each fed by
// a behavioural TDP18K FIFO whose EMPTY flag lags a read by one cycle.
module tb_tdp18k_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus-driven inputs, bit g belongs to instance g.
  logic [1:0] rst   = 2'b11;
  logic [1:0] ready = 2'b00;
  logic [1:0] freq  = 2'b00;
  logic [1:0] under = 2'b00;

  // Observed outputs.
  logic [1:0]       ren, flush_n, mvalid, busy, err;
  logic [1:0][17:0] mdata;
  logic [1:0][15:0] wcnt;
  logic [1:0][1:0]  dbg;

  // Behavioural FIFO storage, one per instance.
  logic [17:0] fmem [2][4096];
  int          fwr [2] = '{0, 0};
  int          frd [2] = '{0, 0};
  logic [1:0]  empty_q = 2'b11;
  logic [1:0]  uflow   = 2'b00;
  logic [17:0] rd0, p1, rd1;

  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];

  tdp18k_fifo_rd_if #(.DW(18)) f_if0 ();
  tdp18k_fifo_rd_if #(.DW(18)) f_if1 ();
  tdp18k_stream_if  #(.DW(18)) s_if0 ();
  tdp18k_stream_if  #(.DW(18)) s_if1 ();

  assign f_if0.FIFO_EMPTY_i    = empty_q[0];
  assign f_if0.FIFO_EPO_i      = ((fwr[0] - frd[0]) == 1);
  assign f_if0.FIFO_UNDERRUN_i = under[0];
  assign f_if0.FIFO_RDATA_i    = rd0;
  assign f_if1.FIFO_EMPTY_i    = empty_q[1];
  assign f_if1.FIFO_EPO_i      = ((fwr[1] - frd[1]) == 1);
  assign f_if1.FIFO_UNDERRUN_i = under[1];
  assign f_if1.FIFO_RDATA_i    = rd1;
  assign s_if0.M_READY_i       = ready[0];
  assign s_if1.M_READY_i       = ready[1];

  assign ren     = {f_if1.FIFO_REN_o, f_if0.FIFO_REN_o};
  assign flush_n = {f_if1.FIFO_FLUSH_no, f_if0.FIFO_FLUSH_no};
  assign mvalid  = {s_if1.M_VALID_o, s_if0.M_VALID_o};
  assign mdata   = {s_if1.M_DATA_o, s_if0.M_DATA_o};

  tdp18k_fifo_rd_stream #(.DATA_WIDTH(18), .RD_LAT(1), .SKID_DEPTH(4), .FLUSH_CYCLES(4)) u_dut0 (
    .CLK_i(clk), .RST_i(rst[0]), .fifo(f_if0), .m_stream(s_if0), .FLUSH_REQ_i(freq[0]),
    .BUSY_o(busy[0]), .ERR_o(err[0]), .WORD_CNT_o(wcnt[0]), .DBG_STATE_o(dbg[0])
  );

  tdp18k_fifo_rd_stream #(.DATA_WIDTH(18), .RD_LAT(2), .SKID_DEPTH(4), .FLUSH_CYCLES(4)) u_dut1 (
    .CLK_i(clk), .RST_i(rst[1]), .fifo(f_if1), .m_stream(s_if1), .FLUSH_REQ_i(freq[1]),
    .BUSY_o(busy[1]), .ERR_o(err[1]), .WORD_CNT_o(wcnt[1]), .DBG_STATE_o(dbg[1])
  );

  // FIFO model: EMPTY reflects the previous cycle's count, EPO the current one.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!flush_n[g]) begin
        frd[g]     <= fwr[g];
        empty_q[g] <= 1'b1;
      end else begin
        empty_q[g] <= (fwr[g] == frd[g]);
        if (ren[g]) begin
          if (fwr[g] == frd[g]) uflow[g] <= 1'b1;
          else                  frd[g]   <= frd[g] + 1;
        end
      end
    end
    if (ren[0]) rd0 <= fmem[0][frd[0] % 4096];
    if (ren[1]) p1  <= fmem[1][frd[1] % 4096];
    rd1 <= p1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push_word(input int s, input logic [17:0] d);
    fmem[s][fwr[s] % 4096] = d;
    fwr[s] = fwr[s] + 1;
    if (s == 0) exp_q0.push_back(d);
    else        exp_q1.push_back(d);
  endtask

  // Scoreboard: every accepted beat must match the head of the expected queue.
  logic [31:0] e0, e1;
  always @(negedge clk) begin
    if (!rst[0] && mvalid[0] && ready[0]) begin
      e0 = (exp_q0.size() > 0) ? {14'd0, exp_q0.pop_front()} : 32'hDEAD_BEEF;
      chk("beat0_data", {14'd0, mdata[0]}, e0);
    end
    if (!rst[1] && mvalid[1] && ready[1]) begin
      e1 = (exp_q1.size() > 0) ? {14'd0, exp_q1.pop_front()} : 32'hDEAD_BEEF;
      chk("beat1_data", {14'd0, mdata[1]}, e1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int found, n, nren, b2b, prev;
    int busy_n, low_n, ren_busy, valid_low, valid_drain;
    logic [1:0] d0;

    repeat (3) step();
    at_neg();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst%0d_ren", g), ren[g], 1'b0);
      chk($sformatf("rst%0d_flush_n", g), flush_n[g], 1'b1);
      chk($sformatf("rst%0d_valid", g), mvalid[g], 1'b0);
      chk($sformatf("rst%0d_data", g), mdata[g], 18'd0);
      chk($sformatf("rst%0d_busy", g), busy[g], 1'b0);
      chk($sformatf("rst%0d_err", g), err[g], 1'b0);
      chk($sformatf("rst%0d_wcnt", g), wcnt[g], 16'd0);
    end

    // 8 preloaded words, consumer always ready, RD_LAT=1.
    step();
    for (int i = 0; i < 8; i++) push_word(0, 18'(i));
    ready[0] = 1'b1;
    step();
    step();
    rst[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      at_neg();
      if (ren[0]) found = 1;
    end
    chk("t1_first_ren", found, 1);
    at_neg();
    chk("t1_valid_at_ren_plus1", mvalid[0], 1'b0);
    at_neg();
    chk("t1_valid_at_ren_plus2", mvalid[0], 1'b1);
    n = int'(mvalid[0]);
    repeat (7) begin
      at_neg();
      n += int'(mvalid[0]);
    end
    chk("t1_consecutive_beats", n, 8);
    at_neg();
    chk("t1_valid_after", mvalid[0], 1'b0);
    chk("t1_wcnt", wcnt[0], 16'd8);

    // Single word: EPO high, EMPTY still low for a cycle after the read.
    step();
    push_word(0, 18'h100);
    nren = 0;
    b2b  = 0;
    prev = 0;
    repeat (8) begin
      at_neg();
      if (ren[0]) nren++;
      if (ren[0] && prev != 0) b2b++;
      prev = int'(ren[0]);
    end
    chk("t2_ren_pulses", nren, 1);
    chk("t2_ren_back_to_back", b2b, 0);
    chk("t2_wcnt", wcnt[0], 16'd9);

    // Backpressure: 10 words, consumer stalled.
    step();
    ready[0] = 1'b0;
    for (int i = 0; i < 10; i++) push_word(0, 18'h200 + 18'(i));
    repeat (12) at_neg();
    chk("t3_words_taken", frd[0] - (fwr[0] - 10), 4);
    chk("t3_valid", mvalid[0], 1'b1);
    chk("t3_data_head", mdata[0], 18'h200);
    chk("t3_err", err[0], 1'b0);
    repeat (3) at_neg();
    chk("t3_data_stable", mdata[0], 18'h200);
    chk("t3_ren_held", ren[0], 1'b0);
    step();
    ready[0] = 1'b1;
    for (int i = 0; i < 60 && exp_q0.size() != 0; i++) at_neg();
    chk("t3_all_delivered", exp_q0.size(), 0);
    at_neg();
    chk("t3_wcnt", wcnt[0], 16'd19);
    chk("t3_valid_after", mvalid[0], 1'b0);
    chk("t3_no_underflow", uflow[0], 1'b0);

    // Flush requested in the cycle of the third REN, two words already in skid.
    step();
    ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) push_word(0, 18'h300 + 18'(i));
    nren = 0;
    for (int i = 0; i < 15 && nren < 3; i++) begin
      at_neg();
      if (ren[0]) nren++;
    end
    chk("t5_third_ren", nren, 3);
    freq[0] = 1'b1;
    step();
    freq[0] = 1'b0;
    busy_n = 0; low_n = 0; ren_busy = 0; valid_low = 0; valid_drain = 0;
    d0 = 2'd3;
    for (int i = 0; i < 12; i++) begin
      at_neg();
      if (i == 0) d0 = dbg[0];
      if (busy[0]) busy_n++;
      if (busy[0] && ren[0]) ren_busy++;
      if (!flush_n[0]) begin
        low_n++;
        if (mvalid[0]) valid_low++;
      end else if (busy[0] && mvalid[0]) begin
        valid_drain++;
      end
    end
    chk("t5_state_drain", d0, 2'd1);
    chk("t5_busy_cycles", busy_n, 6);
    chk("t5_flush_low_cycles", low_n, 4);
    chk("t5_ren_while_busy", ren_busy, 0);
    chk("t5_valid_in_flush", valid_low, 0);
    chk("t5_valid_in_drain", valid_drain, 2);
    chk("t5_valid_after", mvalid[0], 1'b0);
    chk("t5_wcnt_unchanged", wcnt[0], 16'd19);
    exp_q0.delete();

    // Underrun sets sticky error; it survives a flush, reset mid-flush clears it.
    step();
    under[0] = 1'b1;
    step();
    under[0] = 1'b0;
    at_neg();
    chk("t6_err_set", err[0], 1'b1);
    step();
    freq[0] = 1'b1;
    step();
    freq[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      at_neg();
      if (!flush_n[0]) found = 1;
    end
    chk("t6_flush_started", found, 1);
    at_neg();
    chk("t6_err_in_flush", err[0], 1'b1);
    chk("t6_busy_in_flush", busy[0], 1'b1);
    step();
    rst[0] = 1'b1;
    step();
    at_neg();
    chk("t6_rst_flush_n", flush_n[0], 1'b1);
    chk("t6_rst_err", err[0], 1'b0);
    chk("t6_rst_busy", busy[0], 1'b0);
    chk("t6_rst_wcnt", wcnt[0], 16'd0);

    // RD_LAT=2: latency, then 1000 words with random backpressure.
    step();
    for (int i = 0; i < 1000; i++) push_word(1, 18'($urandom_range(0, 262143)));
    step();
    step();
    rst[1] = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      at_neg();
      if (ren[1]) found = 1;
    end
    chk("t4_first_ren", found, 1);
    at_neg();
    at_neg();
    chk("t4_valid_at_ren_plus2", mvalid[1], 1'b0);
    at_neg();
    chk("t4_valid_at_ren_plus3", mvalid[1], 1'b1);
    for (int i = 0; i < 6000 && exp_q1.size() != 0; i++) begin
      step();
      ready[1] = 1'($urandom_range(0, 1));
    end
    chk("t4_all_delivered", exp_q1.size(), 0);
    step();
    ready[1] = 1'b0;
    at_neg();
    chk("t4_wcnt", wcnt[1], 16'd1000);
    chk("t4_err", err[1], 1'b0);
    chk("t4_no_underflow", uflow[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
